// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter.
//   uart_tx_state_t : transmitter frame state
//   UART_DATA_W     : default number of data bits per frame
//   UART_DIV_W      : default width of the baud divider
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

    localparam int UART_DATA_W = 8;
    localparam int UART_DIV_W  = 16;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter for the UART transmitter.
//   main_clk_i  : clock
//   main_rst_i  : synchronous active-high reset
//   div_i       : bit period minus one, in clock cycles
//   restart_i   : start a fresh bit period next cycle
//   tick_o      : high in the last cycle of the current bit period
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             main_clk_i,
    input  logic             main_rst_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             restart_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] r_cnt;

    assign tick_o = (r_cnt == div_i);

    // Wraps to 0 on every tick, so the count never passes div_i.
    always_ff @(posedge main_clk_i) begin
        if (main_rst_i || restart_i || tick_o) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional parity,
// one or two stop bits. Frame settings are captured when a byte is accepted.
//   main_clk_i   : clock
//   main_rst_i   : synchronous active-high reset
//   ena_i        : allow new frames to be accepted
//   baud_div_i   : bit period minus one, in clock cycles
//   parity_ena_i : append a parity bit
//   parity_odd_i : 1 = odd parity, 0 = even parity
//   stop2_i      : 1 = two stop bits
//   tx_valid_i   : byte offered
//   tx_data_i    : byte to send
//   tx_ready_o   : byte accepted this cycle when tx_valid_i is high
//   uart_tx_o    : serial line, idle high
//   busy_o       : frame in progress
//
// state     | meaning
// ST_IDLE   | line high, waiting for an accept
// ST_START  | start bit (line low)
// ST_DATA   | data bits, LSB first
// ST_PARITY | parity bit
// ST_STOP   | one or two stop bits (line high)
module uart_tx
    import uart_pkg::*;
#(
    parameter int DIV_W  = UART_DIV_W,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              main_clk_i,
    input  logic              main_rst_i,
    input  logic              ena_i,
    input  logic [DIV_W-1:0]  baud_div_i,
    input  logic              parity_ena_i,
    input  logic              parity_odd_i,
    input  logic              stop2_i,
    input  logic              tx_valid_i,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              tx_ready_o,
    output logic              uart_tx_o,
    output logic              busy_o
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    uart_tx_state_t    r_state;
    logic [DATA_W-1:0] r_shift;
    logic [DIV_W-1:0]  r_div;
    logic              r_par_ena;
    logic              r_par_bit;
    logic              r_stop2;
    logic [IDX_W-1:0]  r_bit_idx;
    logic              r_tx;
    logic              r_busy;

    logic w_tick;
    logic w_last_stop;
    logic w_ready;
    logic w_accept;

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .main_clk_i (main_clk_i),
        .main_rst_i (main_rst_i),
        .div_i      (r_div),
        .restart_i  (w_accept),
        .tick_o     (w_tick)
    );

    // The bit index doubles as the stop-bit counter while in ST_STOP.
    assign w_last_stop = (r_state == ST_STOP) && w_tick &&
                         (!r_stop2 || (r_bit_idx == IDX_W'(1)));
    // Gated by reset so nothing is offered while the block is held in reset.
    assign w_ready  = ena_i && !main_rst_i && ((r_state == ST_IDLE) || w_last_stop);
    assign w_accept = tx_valid_i && w_ready;

    assign tx_ready_o = w_ready;
    assign uart_tx_o  = r_tx;
    assign busy_o     = r_busy;

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_div     <= '0;
            r_par_ena <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else if (w_accept) begin
            // Covers both IDLE and the final stop cycle (back-to-back frames).
            r_state   <= ST_START;
            r_shift   <= tx_data_i;
            r_div     <= baud_div_i;
            r_par_ena <= parity_ena_i;
            r_par_bit <= (^tx_data_i) ^ parity_odd_i;
            r_stop2   <= stop2_i;
            r_bit_idx <= '0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state   <= ST_DATA;
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == IDX_W'(DATA_W - 1)) begin
                            r_bit_idx <= '0;
                            if (r_par_ena) begin
                                r_state <= ST_PARITY;
                                r_tx    <= r_par_bit;
                            end else begin
                                r_state <= ST_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_state   <= ST_STOP;
                        r_tx      <= 1'b1;
                        r_bit_idx <= '0;
                    end
                end
                ST_STOP: begin
                    if (w_last_stop) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_bit_idx <= '0;
                    end else if (w_tick) begin
                        r_bit_idx <= r_bit_idx + IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DIV_W, default 16: width of the baud divider input.
REQ-002 Parameter DATA_W, default 8: data bits per frame.
REQ-003 Port main_clk_i, input, 1: the block's only clock; all logic is on its rising edge.
REQ-004 Port main_rst_i, input, 1: reset, synchronous and active-high.
REQ-005 Port ena_i, input, 1: transmitter enable; when low, no new frame is accepted.
REQ-006 Port baud_div_i, input, DIV_W: bit period minus one, in main_clk_i cycles.
REQ-007 Port parity_ena_i, input, 1: when high, a parity bit follows the data bits.
REQ-008 Port parity_odd_i, input, 1: 1 selects odd parity, 0 selects even parity.
REQ-009 Port stop2_i, input, 1: 1 selects two stop bits, 0 selects one.
REQ-010 Port tx_valid_i, input, 1: a byte is offered for transmission.
REQ-011 Port tx_data_i, input, DATA_W: the byte offered, LSB first on the line.
REQ-012 Port tx_ready_o, output, 1: the block accepts the offered byte this cycle.
REQ-013 Port uart_tx_o, output, 1: serial line, idle high.
REQ-014 Port busy_o, output, 1: a frame is in progress; status for the register file.

Function
REQ-015 The handshake SHALL be an accept when tx_valid_i and tx_ready_o are both high in the same cycle.
REQ-016 tx_data_i, baud_div_i, parity_ena_i, parity_odd_i and stop2_i SHALL be captured on accept; later changes SHALL NOT affect the frame in progress.
REQ-017 The state machine SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-018 Transitions:
- IDLE to START on accept.
- START to DATA after one bit period.
- DATA to PARITY, or to STOP when parity is disabled, after DATA_W bit periods.
- PARITY to STOP after one bit period.
- STOP to IDLE after one or two bit periods, per stop2.
REQ-019 One bit period SHALL last exactly div+1 cycles, where div is the captured divider; div=0 gives one cycle per bit.
REQ-020 uart_tx_o SHALL be:
- 0 in START;
- data bit n during the n-th DATA period, n=0 first;
- the parity bit in PARITY;
- 1 in STOP and IDLE.
REQ-021 The parity bit SHALL be the XOR of the data bits, inverted when odd parity is selected.
REQ-022 Latency: uart_tx_o SHALL go low in the cycle after accept.
REQ-023 tx_ready_o SHALL be ena_i AND (state is IDLE, OR state is STOP in the final cycle of the final stop bit).
REQ-024 An accept in the final STOP cycle SHALL go directly to START, so back-to-back frames have no idle gap.
REQ-025 busy_o SHALL be high from the cycle after accept until the cycle after the final stop-bit cycle, and low otherwise.
REQ-026 Deasserting ena_i mid-frame SHALL NOT abort the frame; it completes and the block then stays in IDLE.
REQ-027 The bit-period counter and the bit-index counter SHALL wrap to 0 at every bit and state boundary, never counting past div or DATA_W-1.

Reset
REQ-028 While main_rst_i is high at a clock edge, the block SHALL take state IDLE, uart_tx_o=1, busy_o=0, tx_ready_o=0 and all counters 0.
REQ-029 A reset during a frame SHALL abort the frame; uart_tx_o SHALL be 1 from the cycle after reset is sampled.
REQ-030 After reset is released, tx_ready_o SHALL follow REQ-023 from the first cycle.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum uart_tx_state_t and the default constants UART_DATA_W=8 and UART_DIV_W=16.
REQ-032 The bit-period counter SHALL be the single sub-module uart_baud_tick, with inputs div, restart and clock/reset and output tick (last cycle of a bit).
REQ-033 All outputs SHALL be driven directly from registers, except tx_ready_o.

Verification
REQ-034 div=3, no parity, one stop bit, byte 0x55 accepted at cycle 0:
- uart_tx_o low for cycles 1-4;
- then 1,0,1,0,1,0,1,0, four cycles each;
- then high for four cycles;
- busy_o low at cycle 41.
REQ-035 div=0, even parity, byte 0x07: line reads 0,1,1,1,0,0,0,0,0,1(parity),1(stop), one cycle per bit.
REQ-036 div=0, odd parity, two stop bits, byte 0x00: parity bit is 1, followed by two high cycles, then busy_o falls.
REQ-037 tx_valid_i held high with bytes 0xA5 then 0x3C, div=1: second START begins in the cycle immediately after the first frame's last stop cycle, with no idle gap.
REQ-038 Reset asserted during DATA bit 3 of 0xFF: uart_tx_o=1, busy_o=0 and state IDLE in the next cycle; a new accept afterwards sends a correct frame.
REQ-039 ena_i dropped during DATA: the current frame completes, tx_ready_o stays 0, and a pending tx_valid_i is not accepted.
